// File: rtl/mux_arb_n.sv
// N-input registered selector with direct-select and round-robin modes.
// Define MUX_ARB_N_SKID_EN to add a skid entry behind the output register.
module mux_arb_n #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         in_valid,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    output logic [NUM_IN-1:0]         in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_src,
    input  logic                      out_ready
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;

    logic             grant_vld;
    int unsigned      grant_idx;
    int unsigned      idx;
    int unsigned      nxt;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] grant_src;
    logic             can_accept;
    logic             accept;
    logic             pop;

    // Loop bounds keep sel >= NUM_IN from ever matching an input.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 0;
        idx       = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (!grant_vld && sel == i[SEL_W-1:0] && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = i;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                idx = k + 32'(rr_ptr_q);
                if (idx >= NUM_IN) idx = idx - NUM_IN;
                if (!grant_vld && in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx;
                end
            end
        end
    end

    assign grant_data = in_data[grant_idx*WIDTH +: WIDTH];
    assign grant_src  = grant_idx[SEL_W-1:0];
    assign pop        = out_valid_q && out_ready;
    assign accept     = grant_vld && can_accept && !reset;

    always_comb begin
        in_ready = '0;
        if (accept) in_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        nxt      = grant_idx + 1;
        if (nxt >= NUM_IN) nxt = 0;
        rr_ptr_d = rr_ptr_q;
        if (accept && mode) rr_ptr_d = nxt[SEL_W-1:0];
    end

`ifdef MUX_ARB_N_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_src_q, skid_src_d;

    assign can_accept = !skid_valid_q;

    // A parked word always moves ahead of any new grant, preserving order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_src_d   = skid_src_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_src_d    = skid_src_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_src_d   = grant_src;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = grant_data;
            skid_src_d   = grant_src;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_src_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_src_q   <= skid_src_d;
        end
    end
`else
    assign can_accept = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_src_d   = grant_src;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed self-checking bench for mux_arb_n (4 inputs, 64-bit data).
module tb_mux_arb_n;

    localparam int unsigned W  = 64;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready;

    int errors = 0;
    int checks = 0;

    logic [63:0] d [4];

    always #5 clk = ~clk;

    mux_arb_n #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    assign in_data = {d[3], d[2], d[1], d[0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the grant before the edge, then the registered word after it.
    task automatic rr_step(input string tag, input int src, input logic [3:0] rdy);
        #1;
        chk({tag, "_ready"}, 64'(in_ready), 64'(rdy));
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_src"}, 64'(out_src), 64'(src));
        chk({tag, "_data"}, out_data, d[src]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d[0] = 64'h0123_4567_89AB_CDEF;
        d[1] = 64'hFEDC_BA98_7654_3210;
        d[2] = 64'h0000_0000_DEAD_BEEF;
        d[3] = 64'h5A5A_A5A5_0F0F_F0F0;

        reset = 1'b1; in_valid = 4'hF; mode = 1'b1; sel = '0; out_ready = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_src", 64'(out_src), 64'd0);

        reset = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        rr_step("dir2", 2, 4'b0100);

        sel = 2'd1; in_valid = 4'b1101;
        #1;
        chk("dir1_ready", 64'(in_ready), 64'd0);
        tick();
        chk("dir1_valid", 64'(out_valid), 64'd0);

        mode = 1'b1; in_valid = 4'hF;
        for (int k = 0; k < 8; k++) rr_step("rr_all", k % 4, 4'(1 << (k % 4)));

        in_valid = 4'b1101;
        rr_step("rr_skip_a", 0, 4'b0001);
        rr_step("rr_skip_b", 2, 4'b0100);
        rr_step("rr_skip_c", 3, 4'b1000);
        rr_step("rr_skip_d", 0, 4'b0001);

        in_valid = 4'h0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Pointer is 1 here; the first stalled grant goes to input 1.
        in_valid = 4'hF; out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0000;
            if (k == 1) exp_rdy = 4'b0010;
`ifdef MUX_ARB_N_SKID_EN
            if (k == 2) exp_rdy = 4'b0100;
`endif
            #1;
            chk("stall_ready", 64'(in_ready), 64'(exp_rdy));
            tick();
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_src", 64'(out_src), 64'd1);
            chk("stall_data", out_data, d[1]);
        end

        in_valid = 4'h0; out_ready = 1'b1;
        tick();
`ifdef MUX_ARB_N_SKID_EN
        chk("skid_valid", 64'(out_valid), 64'd1);
        chk("skid_src", 64'(out_src), 64'd2);
        chk("skid_data", out_data, d[2]);
        tick();
`endif
        chk("unstall_valid", 64'(out_valid), 64'd0);

        // Either build ends with rr_ptr = 3 after this grant.
        in_valid = 4'b0100;
        rr_step("pre_rst", 2, 4'b0100);

        reset = 1'b1; in_valid = 4'hF;
        #1;
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        tick();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_src", 64'(out_src), 64'd0);

        reset = 1'b0;
        rr_step("post_rst_a", 0, 4'b0001);
        rr_step("post_rst_b", 1, 4'b0010);

        mode = 1'b0; sel = 2'd3;
        rr_step("dir3_a", 3, 4'b1000);
        rr_step("dir3_b", 3, 4'b1000);

        mode = 1'b1;
        rr_step("resume_a", 2, 4'b0100);
        rr_step("resume_b", 3, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
